// File: rtl/intcon_ctrl.sv
// INTCON register + interrupt sequencer; flags set 3 edges after an async input edge (SYNC_STAGES=2), irq one edge later.
// No backpressure: irq is held in PEND until irq_ack, or dropped when the request goes away.
module intcon_ctrl #(
    parameter int SYNC_STAGES = 2  // legal range 2..3
) (
    input  logic       fosc,
    input  logic       mclr,
    input  logic       t0_ovf,
    input  logic       int_pin,
    input  logic       intedg,
    input  logic       rb_chg,
    input  logic       intcon_we,
    input  logic [7:0] intcon_din,
    output logic [7:0] intcon_dout,
    output logic       irq,
    input  logic       irq_ack,
    input  logic       retfie,
    output logic       in_isr
);

    typedef enum logic [1:0] {IDLE, PEND, ISR} state_t;

    logic [SYNC_STAGES-1:0] t0_sync, int_sync, rb_sync;
    logic [SYNC_STAGES:0]   arm_sr;
    logic                   t0_prev, int_prev, rb_prev;
    logic                   t0_s, int_s, rb_s, armed;
    logic                   t0_set, int_set, rb_set;
    logic                   gie, t0ie, inte, rbie, t0if, intf, rbif;
    logic                   pend, gie_clr, gie_set;
    logic                   unused_din6;
    state_t                 state, state_nx;

    assign unused_din6 = intcon_din[6];

    assign t0_s  = t0_sync[SYNC_STAGES-1];
    assign int_s = int_sync[SYNC_STAGES-1];
    assign rb_s  = rb_sync[SYNC_STAGES-1];

    // Edge detection stays off until the prev flops hold a real post-reset
    // sample, so a level already high at release is not seen as an edge.
    assign armed   = arm_sr[SYNC_STAGES];
    assign t0_set  = armed & t0_s & ~t0_prev;
    assign rb_set  = armed & rb_s & ~rb_prev;
    assign int_set = armed & (intedg ? (int_s & ~int_prev) : (~int_s & int_prev));

    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) begin
            t0_sync  <= '0;
            int_sync <= '0;
            rb_sync  <= '0;
            arm_sr   <= '0;
            t0_prev  <= 1'b0;
            int_prev <= 1'b0;
            rb_prev  <= 1'b0;
        end else begin
            t0_sync  <= {t0_sync[SYNC_STAGES-2:0], t0_ovf};
            int_sync <= {int_sync[SYNC_STAGES-2:0], int_pin};
            rb_sync  <= {rb_sync[SYNC_STAGES-2:0], rb_chg};
            arm_sr   <= {arm_sr[SYNC_STAGES-1:0], 1'b1};
            t0_prev  <= t0_s;
            int_prev <= int_s;
            rb_prev  <= rb_s;
        end
    end

    // Hardware sets beat a same-cycle CPU write of 0; sequencer GIE updates beat the written bit 7.
    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) begin
            gie  <= 1'b0;
            t0ie <= 1'b0;
            inte <= 1'b0;
            rbie <= 1'b0;
            t0if <= 1'b0;
            intf <= 1'b0;
            rbif <= 1'b0;
        end else begin
            if (gie_clr)        gie <= 1'b0;
            else if (gie_set)   gie <= 1'b1;
            else if (intcon_we) gie <= intcon_din[7];
            if (intcon_we) begin
                t0ie <= intcon_din[5];
                inte <= intcon_din[4];
                rbie <= intcon_din[3];
            end
            t0if <= t0_set  | (intcon_we ? intcon_din[2] : t0if);
            intf <= int_set | (intcon_we ? intcon_din[1] : intf);
            rbif <= rb_set  | (intcon_we ? intcon_din[0] : rbif);
        end
    end

    assign intcon_dout = {gie, 1'b0, t0ie, inte, rbie, t0if, intf, rbif};
    assign pend        = (t0ie & t0if) | (inte & intf) | (rbie & rbif);

    always_comb begin
        state_nx = state;
        gie_clr  = 1'b0;
        gie_set  = 1'b0;
        case (state)
            IDLE: if (gie && pend) state_nx = PEND;
            PEND: begin
                if (irq_ack) begin
                    gie_clr  = 1'b1;
                    state_nx = ISR;
                end else if (!gie || !pend) begin
                    state_nx = IDLE;
                end
            end
            ISR: begin
                if (retfie) begin
                    gie_set  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge fosc or negedge mclr) begin
        if (!mclr) begin
            state  <= IDLE;
            irq    <= 1'b0;
            in_isr <= 1'b0;
        end else begin
            state  <= state_nx;
            irq    <= (state_nx == PEND);
            in_isr <= (state_nx == ISR);
        end
    end

endmodule

// File: tb/tb_intcon_ctrl.sv
// Directed bench for intcon_ctrl: table of CPU writes plus hand sequences for the interrupt flow.
module tb_intcon_ctrl;

    logic       fosc = 1'b0;
    logic       mclr = 1'b0;
    logic       t0_ovf = 1'b0, int_pin = 1'b0, intedg = 1'b0, rb_chg = 1'b0;
    logic       intcon_we = 1'b0, irq_ack = 1'b0, retfie = 1'b0;
    logic [7:0] intcon_din = 8'h00;
    logic [7:0] intcon_dout;
    logic       irq, in_isr;

    int n_chk  = 0;
    int n_fail = 0;

    intcon_ctrl #(.SYNC_STAGES(2)) dut (
        .fosc(fosc), .mclr(mclr), .t0_ovf(t0_ovf), .int_pin(int_pin),
        .intedg(intedg), .rb_chg(rb_chg), .intcon_we(intcon_we),
        .intcon_din(intcon_din), .intcon_dout(intcon_dout), .irq(irq),
        .irq_ack(irq_ack), .retfie(retfie), .in_isr(in_isr)
    );

    always #5 fosc = ~fosc;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        logic       irq;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge fosc);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] d);
        intcon_we  = 1'b1;
        intcon_din = d;
        tick();
        intcon_we  = 1'b0;
    endtask

    task automatic do_reset();
        t0_ovf = 1'b0; int_pin = 1'b0; rb_chg = 1'b0;
        intcon_we = 1'b0; irq_ack = 1'b0; retfie = 1'b0;
        mclr = 1'b0;
        tick(2);
        mclr = 1'b1;
        tick(4);
    endtask

    initial begin
        vecs[0]  = '{8'hFF, 8'hBF, 1'b1};
        vecs[1]  = '{8'h00, 8'h00, 1'b0};
        vecs[2]  = '{8'h40, 8'h00, 1'b0};
        vecs[3]  = '{8'h3F, 8'h3F, 1'b0};
        vecs[4]  = '{8'h90, 8'h90, 1'b0};
        vecs[5]  = '{8'h92, 8'h92, 1'b1};
        vecs[6]  = '{8'h8A, 8'h8A, 1'b0};
        vecs[7]  = '{8'h89, 8'h89, 1'b1};
        vecs[8]  = '{8'h09, 8'h09, 1'b0};
        vecs[9]  = '{8'hA4, 8'hA4, 1'b1};
        vecs[10] = '{8'h00, 8'h00, 1'b0};

        // Reset state
        #3;
        chk("rst_dout", intcon_dout, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_isr", {7'b0, in_isr}, 8'h00);
        tick(2);
        mclr = 1'b1;
        tick(4);

        // CPU write table: read-back after the write edge, irq one edge later
        for (int i = 0; i < 11; i++) begin
            wr(vecs[i].din);
            chk($sformatf("tbl%0d_dout", i), intcon_dout, vecs[i].dout);
            tick();
            chk($sformatf("tbl%0d_irq", i), {7'b0, irq}, {7'b0, vecs[i].irq});
        end

        // Timer0 flow: flag at edge 3, irq at edge 4, then acknowledge
        do_reset();
        wr(8'hA0);
        t0_ovf = 1'b1;
        tick(2);
        chk("t0_edge2_flag", {7'b0, intcon_dout[2]}, 8'h00);
        tick();
        chk("t0_edge3_flag", {7'b0, intcon_dout[2]}, 8'h01);
        chk("t0_edge3_irq", {7'b0, irq}, 8'h00);
        tick();
        chk("t0_edge4_irq", {7'b0, irq}, 8'h01);
        t0_ovf  = 1'b0;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("ack_dout", intcon_dout, 8'h24);
        chk("ack_irq", {7'b0, irq}, 8'h00);
        chk("ack_isr", {7'b0, in_isr}, 8'h01);

        // In ISR: port-B change sets RBIF without irq; retfie with a GIE=0 write
        wr(8'h08);
        rb_chg = 1'b1;
        tick(3);
        rb_chg = 1'b0;
        chk("isr_rbif", intcon_dout, 8'h09);
        tick(3);
        chk("isr_irq_low", {7'b0, irq}, 8'h00);
        chk("isr_still", {7'b0, in_isr}, 8'h01);
        retfie     = 1'b1;
        intcon_we  = 1'b1;
        intcon_din = 8'h09;
        tick();
        retfie    = 1'b0;
        intcon_we = 1'b0;
        chk("retfie_gie", intcon_dout, 8'h89);
        chk("retfie_isr", {7'b0, in_isr}, 8'h00);
        tick();
        chk("retfie_reirq", {7'b0, irq}, 8'h01);

        // Falling-edge INT, plus stray retfie/irq_ack outside their states
        do_reset();
        intedg = 1'b0;
        wr(8'h10);
        retfie = 1'b1;
        tick();
        retfie = 1'b0;
        chk("stray_retfie", intcon_dout, 8'h10);
        wr(8'h90);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("stray_ack_dout", intcon_dout, 8'h90);
        chk("stray_ack_isr", {7'b0, in_isr}, 8'h00);
        int_pin = 1'b1;
        tick(5);
        chk("int_rise_noflag", intcon_dout, 8'h90);
        chk("int_rise_noirq", {7'b0, irq}, 8'h00);
        int_pin = 1'b0;
        tick(3);
        chk("int_fall_flag", intcon_dout, 8'h92);
        tick();
        chk("int_fall_irq", {7'b0, irq}, 8'h01);

        // PEND withdrawn by software clear, then clear racing a hardware set
        do_reset();
        wr(8'hA0);
        t0_ovf = 1'b1;
        tick(4);
        chk("pend_irq", {7'b0, irq}, 8'h01);
        wr(8'hA0);
        chk("swclr_dout", intcon_dout, 8'hA0);
        tick();
        chk("swclr_irq", {7'b0, irq}, 8'h00);
        t0_ovf = 1'b0;
        tick(4);
        wr(8'hA4);
        tick();
        chk("pend2_irq", {7'b0, irq}, 8'h01);
        t0_ovf = 1'b1;
        tick(2);
        wr(8'hA0);
        chk("race_flag", intcon_dout, 8'hA4);
        chk("race_irq", {7'b0, irq}, 8'h01);
        tick();
        chk("race_irq_hold", {7'b0, irq}, 8'h01);

        // Reset during ISR with t0_ovf held high across release
        do_reset();
        wr(8'hA0);
        t0_ovf = 1'b1;
        tick(4);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        chk("pre_rst_isr", {7'b0, in_isr}, 8'h01);
        #2 mclr = 1'b0;
        #1;
        chk("midrst_dout", intcon_dout, 8'h00);
        chk("midrst_irq", {7'b0, irq}, 8'h00);
        chk("midrst_isr", {7'b0, in_isr}, 8'h00);
        tick(2);
        mclr = 1'b1;
        tick(6);
        chk("rel_high_noflag", intcon_dout, 8'h00);
        chk("rel_high_noirq", {7'b0, irq}, 8'h00);
        t0_ovf = 1'b0;
        tick(3);
        t0_ovf = 1'b1;
        tick(3);
        chk("post_rst_edge", intcon_dout, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
